dut_host_initiator: RTL

Bus initiator that drives the register-mapped write/read interface of the OR-combiner DUT. It accepts one operand pair (a, b) on a valid/ready command port and writes a to the A register and b to the B register. It then polls the Y-status register, reads and dequeues Y, and returns the result on a valid/ready response port. It sits between the test/host logic and the DUT and handles one transaction at a time.

---
 rtl/dut_host_initiator_pkg.sv | 31 +++
 rtl/dut_host_poll_timer.sv | 41 ++++
 rtl/dut_host_initiator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dut_host_initiator_pkg.sv
// Shared definitions for the OR-combiner host initiator.
//   - state_t        : initiator FSM state encoding (6 states, 3 bits)
//   - ADDR_*_DEF     : DUT register addresses used as parameter defaults
//   - STATUS_YVALID_BIT : bit of the status word that flags "Y not empty"
//   - DATA_W         : DUT data path width
//   - sat_inc8       : saturating 8-bit increment
package dut_host_initiator_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] ADDR_A_DEF      = 3'd0;
  localparam logic [2:0] ADDR_B_DEF      = 3'd5;
  localparam logic [2:0] ADDR_STATUS_DEF = 3'd2;
  localparam logic [2:0] ADDR_Y_DEF      = 3'd3;

  localparam int STATUS_YVALID_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_WR_B = 3'd2,
    ST_POLL = 3'd3,
    ST_RD_Y = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dut_host_poll_timer.sv
// Loadable cycle counter with clear, enable and terminal-count flag.
// Counting stops at the terminal value, so it never wraps.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset (count -> 0)
//   i_clr       : synchronous clear (highest priority)
//   i_load      : load i_load_val
//   i_load_val  : value to load
//   i_en        : advance count by one
//   o_tc        : count equals terminal value TC
module dut_host_poll_timer #(
  parameter int TC = 299,
  parameter int W  = (TC > 0) ? $clog2(TC + 1) : 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != TC_V)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == TC_V);

endmodule

// File: rtl/dut_host_initiator.sv
// Bus initiator for the register-mapped OR-combiner DUT.
// Takes one (a, b) command, writes a then b to the DUT, polls the Y status
// register, reads/dequeues Y once and returns it on the response port.
// A poll that runs TIMEOUT cycles without seeing Y aborts with rsp_timeout=1.
// Ports:
//   CLK, RST                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_a/cmd_b: command handshake and operands
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data/rsp_timeout           : Y value (0 on abort) and abort flag
//   write_address/data/en, write_rdy : DUT write port
//   read_address/en, read_data, read_rdy : DUT read port (read_en dequeues Y)
//   busy                           : not in IDLE
//   timeout_count                  : aborts since reset, saturating at 255
module dut_host_initiator
  import dut_host_initiator_pkg::*;
#(
  parameter logic [2:0] ADDR_A      = ADDR_A_DEF,
  parameter logic [2:0] ADDR_B      = ADDR_B_DEF,
  parameter logic [2:0] ADDR_STATUS = ADDR_STATUS_DEF,
  parameter logic [2:0] ADDR_Y      = ADDR_Y_DEF,
  parameter int         TIMEOUT     = 300
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [2:0]        write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [2:0]        read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              busy,
  output logic [7:0]        timeout_count
);

  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_timeout;
  logic [7:0]        r_timeout_count;

  logic w_status_hit;
  logic w_poll_clr;
  logic w_poll_en;
  logic w_poll_tc;

  assign w_status_hit = read_rdy && read_data[STATUS_YVALID_BIT];

  // Held at zero outside POLL, so every poll phase starts from a fresh count.
  assign w_poll_clr = (r_state != ST_POLL);
  assign w_poll_en  = (r_state == ST_POLL) && !w_status_hit;

  dut_host_poll_timer #(
    .TC (TIMEOUT - 1),
    .W  (PW)
  ) u_poll_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_clr      (w_poll_clr),
    .i_load     (1'b0),
    .i_load_val ({PW{1'b0}}),
    .i_en       (w_poll_en),
    .o_tc       (w_poll_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= ST_IDLE;
      r_a             <= '0;
      r_b             <= '0;
      r_rsp_data      <= '0;
      r_rsp_timeout   <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_state <= ST_WR_A;
          end
        end
        ST_WR_A: begin
          if (write_rdy) r_state <= ST_WR_B;
        end
        ST_WR_B: begin
          if (write_rdy) r_state <= ST_POLL;
        end
        ST_POLL: begin
          if (w_status_hit) begin
            r_state <= ST_RD_Y;
          end else if (w_poll_tc) begin
            // This cycle is the TIMEOUT-th unsuccessful poll: abort.
            r_rsp_data      <= '0;
            r_rsp_timeout   <= 1'b1;
            r_timeout_count <= sat_inc8(r_timeout_count);
            r_state         <= ST_RESP;
          end
        end
        ST_RD_Y: begin
          if (read_rdy) begin
            r_rsp_data    <= read_data;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus and handshake outputs depend on the state register only.
  assign cmd_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_data      = r_rsp_data;
  assign rsp_timeout   = r_rsp_timeout;
  assign timeout_count = r_timeout_count;

  assign write_en      = (r_state == ST_WR_A) || (r_state == ST_WR_B);
  assign write_address = (r_state == ST_WR_A) ? ADDR_A :
                         (r_state == ST_WR_B) ? ADDR_B : 3'd0;
  assign write_data    = (r_state == ST_WR_A) ? r_a :
                         (r_state == ST_WR_B) ? r_b : '0;

  assign read_en       = (r_state == ST_RD_Y);
  assign read_address  = (r_state == ST_POLL) ? ADDR_STATUS :
                         (r_state == ST_RD_Y) ? ADDR_Y : 3'd0;

endmodule
